// File: rtl/dtpu_host_pkg.sv
// Shared state and error-code encodings for the DTPU host sequencer.
// The watchdog variant is built with DTPU_HOST_WATCHDOG_EN defined.
package dtpu_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_START     = 3'd2,
        ST_RUN       = 3'd3,
        ST_ERROR     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2
    } err_e;

    // States in which an abort cancels the job in flight.
    function automatic logic is_active(input state_e s);
        return (s == ST_WAIT_IDLE) || (s == ST_START) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/dtpu_watchdog.sv
// Per-run countdown: loads TIMEOUT_CYCLES-1 on clear and counts down while run is high.
// Only instantiated when DTPU_HOST_WATCHDOG_EN is defined.
module dtpu_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LOAD_VAL;
        end else if (run && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && (count_q == '0);

endmodule

// File: rtl/dtpu_host_sequencer.sv
// Host-side initiator for the DTPU start/ready/done/idle handshake, running N back-to-back jobs.
// Define DTPU_HOST_WATCHDOG_EN to add the per-run timeout and the ERROR state.
module dtpu_host_sequencer
    import dtpu_host_pkg::*;
#(
    parameter int JOB_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    input  logic [JOB_CNT_W-1:0] job_count,
    output logic                 job_ready,
    input  logic                 abort,
    output logic                 glb_enable,
    output logic                 cs_start,
    output logic                 cs_continue,
    input  logic                 cs_ready,
    input  logic                 cs_done,
    input  logic                 cs_idle,
    output logic                 busy,
    output logic                 job_done,
    output logic [JOB_CNT_W-1:0] runs_completed,
    output logic [1:0]           error_code,
    output logic [2:0]           state_out
);

    state_e               state_d, state_q;
    logic [JOB_CNT_W-1:0] remaining_d, remaining_q;
    logic [JOB_CNT_W-1:0] runs_d, runs_q;
    err_e                 err_d, err_q;
    logic                 glb_d, glb_q;
    logic                 start_d, start_q;
    logic                 done_d, done_q;
    logic                 job_ready_d, job_ready_q;
    logic                 busy_d, busy_q;
    logic                 run_done;
    logic                 timeout;

`ifdef DTPU_HOST_WATCHDOG_EN
    logic wd_clear;

    assign wd_clear = (state_d == ST_START) && (state_q != ST_START);

    dtpu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (wd_clear),
        .run    ((state_q == ST_START) || (state_q == ST_RUN)),
        .expired(timeout)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    // Ready and done sampled together in START count as ready followed by done.
    assign run_done = ((state_q == ST_RUN) && cs_done) ||
                      ((state_q == ST_START) && cs_ready && cs_done);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        runs_d      = runs_q;
        err_d       = err_q;
        glb_d       = glb_q;
        start_d     = start_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready_q) begin
                    runs_d = '0;
                    err_d  = ERR_NONE;
                    if (job_count != '0) begin
                        remaining_d = job_count;
                        glb_d       = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (cs_idle) begin
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START, ST_RUN: begin
                if (run_done) begin
                    start_d     = 1'b0;
                    remaining_d = remaining_q - JOB_CNT_W'(1);
                    if (runs_q != '1) begin
                        runs_d = runs_q + JOB_CNT_W'(1);
                    end
                    if (remaining_q == JOB_CNT_W'(1)) begin
                        glb_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (timeout) begin
                    start_d = 1'b0;
                    glb_d   = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end else if ((state_q == ST_START) && cs_ready) begin
                    start_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                glb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides ready, done and timeout; completed runs are kept.
        if (abort && is_active(state_q)) begin
            state_d     = ST_IDLE;
            start_d     = 1'b0;
            glb_d       = 1'b0;
            done_d      = 1'b0;
            err_d       = ERR_ABORT;
            runs_d      = runs_q;
            remaining_d = remaining_q;
        end

        job_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            runs_q      <= '0;
            err_q       <= ERR_NONE;
            glb_q       <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            runs_q      <= runs_d;
            err_q       <= err_d;
            glb_q       <= glb_d;
            start_q     <= start_d;
            done_q      <= done_d;
            job_ready_q <= job_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign job_ready      = job_ready_q;
    assign glb_enable     = glb_q;
    assign cs_start       = start_q;
    assign cs_continue    = 1'b0;
    assign busy           = busy_q;
    assign job_done       = done_q;
    assign runs_completed = runs_q;
    assign error_code     = err_q;
    assign state_out      = state_q;

endmodule
